// File: rtl/edu_token_scanner.sv
// ---------------------------------------------------------------------------
// edu_token_scanner
//
// Purpose:
//   Captures a NUM_ROW x NUM_COL grid of ESM-head flags (minus flagged-out
//   qubits) on a load request and emits their (row, column) coordinates as
//   tokens in row-major order over a valid/ready handshake. In "all" mode
//   every set bit becomes a token. Otherwise only the first set bit of each
//   row becomes a token, and accepting it retires the whole row.
//
// Ports:
//   clk          in   single clock, rising edge
//   rst_n        in   synchronous active-low reset
//   load         in   capture request, honoured only in IDLE
//   mode_all     in   1 = every bit, 0 = first bit per row (captured with load)
//   esmhead      in   NUM_ROW*NUM_COL flags, row r col c at bit r*NUM_COL+c
//   flag_out     in   NUM_ROW*NUM_COL flagged-out qubits, same packing
//   token_valid  out  token_row/token_col hold a valid token
//   token_ready  in   consumer accepts the token when high with token_valid
//   token_row    out  row of the current token (0 when no token)
//   token_col    out  column of the current token (0 when no token)
//   busy         out  high in SCAN and DONE
//   done         out  one-cycle pulse once every token of the load is taken
//   token_cnt    out  tokens accepted since the last accepted load
// ---------------------------------------------------------------------------
module edu_token_scanner #(
    parameter int NUM_ROW    = 4,
    parameter int NUM_COL    = 8,
    parameter int ROWADDR_BW = 2,
    parameter int COLADDR_BW = 3
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               load,
    input  logic                               mode_all,
    input  logic [NUM_ROW*NUM_COL-1:0]         esmhead,
    input  logic [NUM_ROW*NUM_COL-1:0]         flag_out,
    output logic                               token_valid,
    input  logic                               token_ready,
    output logic [ROWADDR_BW-1:0]              token_row,
    output logic [COLADDR_BW-1:0]              token_col,
    output logic                               busy,
    output logic                               done,
    output logic [ROWADDR_BW+COLADDR_BW:0]     token_cnt
);

    localparam int NUM_BIT = NUM_ROW * NUM_COL;
    localparam int CNT_BW  = ROWADDR_BW + COLADDR_BW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state;
    logic [NUM_BIT-1:0] mask;
    logic               mode_reg;

    logic                  found;
    logic [ROWADDR_BW-1:0] sel_row;
    logic [COLADDR_BW-1:0] sel_col;
    logic [NUM_BIT-1:0]    clr_mask;
    logic [NUM_BIT-1:0]    mask_after;
    logic                  accept;

    // Row-major priority encoder over the registered mask: the first set bit
    // met while walking rows then columns upward wins.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and a latch is never inferred.
        found   = 1'b0;
        sel_row = '0;
        sel_col = '0;
        for (int r = 0; r < NUM_ROW; r++) begin
            for (int c = 0; c < NUM_COL; c++) begin
                if (!found && mask[r*NUM_COL + c]) begin
                    found   = 1'b1;
                    sel_row = ROWADDR_BW'(r);
                    sel_col = COLADDR_BW'(c);
                end
            end
        end
    end

    // The mask is only ever nonzero in SCAN; qualifying with the state keeps
    // that invariant explicit at the output.
    assign token_valid = (state == ST_SCAN) && found;
    assign token_row   = token_valid ? sel_row : '0;
    assign token_col   = token_valid ? sel_col : '0;
    assign accept      = token_valid && token_ready;

    // Bits retired by an accept: just the emitted bit in "all" mode, the
    // emitted bit's whole row in first-per-row mode.
    always_comb begin
        clr_mask = '0;
        for (int r = 0; r < NUM_ROW; r++) begin
            for (int c = 0; c < NUM_COL; c++) begin
                if (ROWADDR_BW'(r) == sel_row &&
                    (!mode_reg || COLADDR_BW'(c) == sel_col)) begin
                    clr_mask[r*NUM_COL + c] = 1'b1;
                end
            end
        end
    end

    assign mask_after = accept ? (mask & ~clr_mask) : mask;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state     <= ST_IDLE;
            mask      <= '0;
            mode_reg  <= 1'b0;
            token_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (load) begin
                        mask      <= esmhead & ~flag_out;
                        mode_reg  <= mode_all;
                        token_cnt <= '0;
                        state     <= ST_SCAN;
                        busy      <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    mask <= mask_after;
                    if (accept) begin
                        token_cnt <= token_cnt + CNT_BW'(1);
                    end
                    // Leave as soon as nothing remains: covers an empty
                    // capture and the cycle of the final accept alike.
                    if (mask_after == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    mask  <= '0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_edu_token_scanner.sv
// ---------------------------------------------------------------------------
// tb_edu_token_scanner
//
// Table-driven directed bench for edu_token_scanner (NUM_ROW=4, NUM_COL=8).
// Inputs change and outputs are compared on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_edu_token_scanner;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic        mode_all;
    logic [31:0] esmhead;
    logic [31:0] flag_out;
    logic        token_valid;
    logic        token_ready;
    logic [1:0]  token_row;
    logic [2:0]  token_col;
    logic        busy;
    logic        done;
    logic [5:0]  token_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    edu_token_scanner #(
        .NUM_ROW(4), .NUM_COL(8), .ROWADDR_BW(2), .COLADDR_BW(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .mode_all(mode_all),
        .esmhead(esmhead), .flag_out(flag_out), .token_valid(token_valid),
        .token_ready(token_ready), .token_row(token_row),
        .token_col(token_col), .busy(busy), .done(done),
        .token_cnt(token_cnt)
    );

    // One load scenario: inputs plus the expected token bit indices in order.
    typedef struct {
        string            name;
        logic             mode;
        logic [31:0]      esm;
        logic [31:0]      flg;
        int               ntok;
        logic [3:0][4:0]  toks;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp,
                     $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic expect_token(input string tag, input int idx,
                                input int cnt);
        check({tag, " valid"}, 32'(token_valid), 1);
        check({tag, " row"},   32'(token_row),   32'(idx / 8));
        check({tag, " col"},   32'(token_col),   32'(idx % 8));
        check({tag, " busy"},  32'(busy),        1);
        check({tag, " done"},  32'(done),        0);
        check({tag, " cnt"},   32'(token_cnt),   32'(cnt));
    endtask

    task automatic expect_done(input string tag, input int cnt);
        check({tag, " done pulse"}, 32'(done),        1);
        check({tag, " done busy"},  32'(busy),        1);
        check({tag, " done valid"}, 32'(token_valid), 0);
        check({tag, " done row0"},  32'(token_row),   0);
        check({tag, " done col0"},  32'(token_col),   0);
        check({tag, " done cnt"},   32'(token_cnt),   32'(cnt));
        step();
        check({tag, " idle done"},  32'(done),        0);
        check({tag, " idle busy"},  32'(busy),        0);
        check({tag, " idle cnt"},   32'(token_cnt),   32'(cnt));
    endtask

    task automatic do_load(input logic m, input logic [31:0] e,
                           input logic [31:0] f);
        load     = 1'b1;
        mode_all = m;
        esmhead  = e;
        flag_out = f;
        step();
        load     = 1'b0;
    endtask

    initial begin
        vecs[0] = '{name: "v032", mode: 1'b1,
                    esm: (32'd1<<3)|(32'd1<<9)|(32'd1<<10)|(32'd1<<31),
                    flg: (32'd1<<9), ntok: 3,
                    toks: {5'd0, 5'd31, 5'd10, 5'd3}};
        vecs[1] = '{name: "v033", mode: 1'b0,
                    esm: (32'd1<<3)|(32'd1<<5)|(32'd1<<10)|(32'd1<<12),
                    flg: (32'd1<<9), ntok: 2,
                    toks: {5'd0, 5'd0, 5'd10, 5'd3}};
        vecs[2] = '{name: "v034", mode: 1'b1, esm: 32'hFFFF_FFFF,
                    flg: 32'hFFFF_FFFF, ntok: 0, toks: '0};
        vecs[3] = '{name: "vrow", mode: 1'b0,
                    esm: (32'd1<<7)|(32'd1<<8)|(32'd1<<15)|(32'd1<<30),
                    flg: 32'd0, ntok: 3,
                    toks: {5'd0, 5'd30, 5'd8, 5'd7}};
        vecs[4] = '{name: "vskip", mode: 1'b1,
                    esm: (32'd1<<0)|(32'd1<<17)|(32'd1<<20),
                    flg: (32'd1<<20), ntok: 2,
                    toks: {5'd0, 5'd0, 5'd17, 5'd0}};

        rst_n = 1'b0; load = 1'b0; mode_all = 1'b0; esmhead = '0;
        flag_out = '0; token_ready = 1'b0;
        step(); step();
        check("reset valid", 32'(token_valid), 0);
        check("reset busy",  32'(busy),        0);
        check("reset done",  32'(done),        0);
        check("reset row",   32'(token_row),   0);
        check("reset col",   32'(token_col),   0);
        check("reset cnt",   32'(token_cnt),   0);
        rst_n = 1'b1;
        step();

        // Table: load, stream with token_ready high, then done and idle.
        token_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            do_load(vecs[v].mode, vecs[v].esm, vecs[v].flg);
            if (vecs[v].ntok == 0) begin
                check({vecs[v].name, " empty valid"}, 32'(token_valid), 0);
                check({vecs[v].name, " empty busy"},  32'(busy),        1);
                check({vecs[v].name, " empty done"},  32'(done),        0);
                step();
            end
            for (int i = 0; i < vecs[v].ntok; i++) begin
                expect_token($sformatf("%s tok%0d", vecs[v].name, i),
                             int'(vecs[v].toks[i]), i);
                step();
            end
            expect_done(vecs[v].name, vecs[v].ntok);
        end

        // Back-pressure: token held stable for 3 cycles; load ignored.
        token_ready = 1'b0;
        do_load(vecs[0].mode, vecs[0].esm, vecs[0].flg);
        for (int i = 0; i < 3; i++) begin
            expect_token($sformatf("stall%0d", i), 3, 0);
            if (i == 1) begin
                load = 1'b1; mode_all = 1'b0; esmhead = 32'h0000_0001;
                flag_out = '0;
            end else begin
                load = 1'b0;
            end
            step();
        end
        load = 1'b0;
        token_ready = 1'b1;
        expect_token("stall go0", 3, 0);
        step();
        expect_token("stall go1", 10, 1);
        step();
        expect_token("stall go2", 31, 2);
        step();
        expect_done("stall", 3);

        // Reset mid-scan after one accept: no done pulse, count cleared.
        do_load(vecs[0].mode, vecs[0].esm, vecs[0].flg);
        expect_token("rst tok0", 3, 0);
        step();
        expect_token("rst tok1", 10, 1);
        rst_n = 1'b0;
        load  = 1'b1;
        step();
        load  = 1'b0;
        check("midrst valid", 32'(token_valid), 0);
        check("midrst busy",  32'(busy),        0);
        check("midrst done",  32'(done),        0);
        check("midrst cnt",   32'(token_cnt),   0);
        check("midrst row",   32'(token_row),   0);
        rst_n = 1'b1;
        step();
        check("midrst after done", 32'(done), 0);
        check("midrst after busy", 32'(busy), 0);

        // Full grid in "all" mode: 32 back-to-back tokens.
        do_load(1'b1, 32'hFFFF_FFFF, 32'h0);
        for (int i = 0; i < 32; i++) begin
            expect_token($sformatf("full tok%0d", i), i, i);
            step();
        end
        expect_done("full", 32);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/edu_token_scanner.md
EDU_TOKEN_SCANNER -- requirements
Module: edu_token_scanner

Interface
REQ-001 Parameter NUM_ROW, default 4: number of ancilla rows scanned per load.
REQ-002 Parameter NUM_COL, default 8: number of ancilla columns per row.
REQ-003 Parameter ROWADDR_BW, default 2: row index width; SHALL hold >= clog2(NUM_ROW), minimum 1.
REQ-004 Parameter COLADDR_BW, default 3: column index width; SHALL hold >= clog2(NUM_COL), minimum 1.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 load  input  1  capture request; sampled only in IDLE.
REQ-008 mode_all  input  1  1 = emit every syndrome bit; 0 = emit first bit per row only; captured with load.
REQ-009 esmhead  input  NUM_ROW*NUM_COL  ESM-head flags, row r column c at bit r*NUM_COL+c.
REQ-010 flag_out  input  NUM_ROW*NUM_COL  flagged-out qubits, same packing.
REQ-011 token_valid  output  1  token_row/token_col hold a valid token.
REQ-012 token_ready  input  1  consumer accepts token when high with token_valid.
REQ-013 token_row  output  ROWADDR_BW  row of current token.
REQ-014 token_col  output  COLADDR_BW  column of current token.
REQ-015 busy  output  1  high in SCAN and DONE.
REQ-016 done  output  1  one-cycle pulse: all tokens of current load consumed.
REQ-017 token_cnt  output  ROWADDR_BW+COLADDR_BW+1  tokens accepted since last load.

Function
REQ-018 States: IDLE, SCAN, DONE; encoding free.
REQ-019 IDLE with load=1: register mask <= esmhead & ~flag_out, mode register <= mode_all, token_cnt <= 0, next state SCAN.
REQ-020 load in SCAN/DONE SHALL be ignored; mask, mode, count unchanged.
REQ-021 In SCAN, current token = lowest set mask bit in row-major order (lowest row, then lowest column in that row); token_valid = 1 iff mask nonzero.
REQ-022 token_row/token_col/token_valid combinational from registered mask only; first token visible the cycle after load, no dependence on token_ready.
REQ-023 Accept (token_valid & token_ready): mode_all=1 clears only the emitted bit; mode_all=0 clears the whole emitted row; token_cnt increments by 1.
REQ-024 Throughput: one token per cycle while token_ready held high; no bubble cycles for empty rows.
REQ-025 While token_valid=1 and token_ready=0, token_row/token_col SHALL stay stable.
REQ-026 SCAN with mask zero (incl. zero at capture, or after final accept) -> DONE next cycle; token_valid=0 whenever mask zero.
REQ-027 DONE: done=1, busy=1, token_valid=0 for exactly one cycle, then IDLE.
REQ-028 token_cnt holds its value through DONE and IDLE until next accepted load; cannot overflow (max NUM_ROW*NUM_COL).
REQ-029 token_row/token_col SHALL read 0 when token_valid=0.

Reset
REQ-030 rst_n=0 at a rising edge: state IDLE, mask 0, mode 0, token_cnt 0; next cycle token_valid=0, busy=0, done=0, token_row=0, token_col=0.
REQ-031 Reset mid-SCAN SHALL discard pending tokens without a done pulse; reset has priority over load and accept in the same cycle.

Verification (NUM_ROW=4, NUM_COL=8)
REQ-032 mode_all=1, esmhead bits {3,9,10,31}, flag_out bit 9, token_ready=1 -> tokens (0,3),(1,2),(3,7) on consecutive cycles, done pulse next cycle, token_cnt=3.
REQ-033 Same load, mode_all=0, esmhead bits {3,5,10,12} -> tokens (0,3),(1,2) only, token_cnt=2.
REQ-034 esmhead all-ones, flag_out all-ones -> no token_valid, done one cycle after SCAN entry, token_cnt=0.
REQ-035 token_ready low 3 cycles with token (0,3) pending -> outputs stable (0,3), token_cnt unchanged; load pulsed meanwhile ignored.
REQ-036 rst_n low during SCAN after 1 of 3 tokens accepted -> next cycle token_valid=0, busy=0, token_cnt=0, no done pulse.
REQ-037 mode_all=1, esmhead all-ones, flag_out 0, token_ready=1 -> 32 tokens in row-major order on 32 consecutive cycles, token_cnt=32.
